// File: rtl/vga_timing_core.sv
// Parametrised VGA timing core: pixel-rate divider, h/v counters, registered
// sync/RGB outputs with blanking, frame-start strobe and frame-counted blink flag.
`timescale 1ns/1ps
module vga_timing_core #(
  parameter int CLK_DIV      = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int HS_POL       = 0,
  parameter int VS_POL       = 0,
  parameter int COLOR_W      = 12,
  parameter int CNT_W        = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               CLK_NX,
  input  logic               reset,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               blink_en,
  output logic               pixel_tick,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [CNT_W-1:0]   pixel_y,
  output logic               h_sync,
  output logic               v_sync,
  output logic               video_on,
  output logic [COLOR_W-1:0] RGB,
  output logic               frame_start,
  output logic               blink
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(BLINK_FRAMES - 1);
  localparam logic             HS_ON   = (HS_POL != 0);
  localparam logic             VS_ON   = (VS_POL != 0);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               video_on_q, video_on_d;
  logic               h_sync_q, h_sync_d;
  logic               v_sync_q, v_sync_d;
  logic [FC_W-1:0]    fc_q, fc_d;
  logic               blink_q, blink_d;

  logic vis, hs_act, vs_act, h_wrap, v_wrap;

  // Gating with reset keeps the tick low during reset even when CLK_DIV==1.
  assign pixel_tick  = reset && (div_q == DIV_MAX);
  assign h_wrap      = (h_cnt_q == H_MAX);
  assign v_wrap      = (v_cnt_q == V_MAX);
  assign frame_start = pixel_tick && h_wrap && v_wrap;

  assign vis    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hs_act = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
  assign vs_act = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);

  always_comb begin
    div_d      = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    rgb_d      = rgb_q;
    video_on_d = video_on_q;
    h_sync_d   = h_sync_q;
    v_sync_d   = v_sync_q;
    fc_d       = fc_q;
    blink_d    = blink_q;

    if (pixel_tick) begin
      rgb_d      = vis ? color_in : '0;
      video_on_d = vis;
      h_sync_d   = hs_act ? HS_ON : ~HS_ON;
      v_sync_d   = vs_act ? VS_ON : ~VS_ON;
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    if (!blink_en) begin
      fc_d    = '0;
      blink_d = 1'b0;
    end else if (frame_start) begin
      if (fc_q == FC_MAX) begin
        fc_d    = '0;
        blink_d = ~blink_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_NX or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      rgb_q      <= '0;
      video_on_q <= 1'b0;
      h_sync_q   <= ~HS_ON;
      v_sync_q   <= ~VS_ON;
      fc_q       <= '0;
      blink_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      rgb_q      <= rgb_d;
      video_on_q <= video_on_d;
      h_sync_q   <= h_sync_d;
      v_sync_q   <= v_sync_d;
      fc_q       <= fc_d;
      blink_q    <= blink_d;
    end
  end

  assign pixel_x  = h_cnt_q;
  assign pixel_y  = v_cnt_q;
  assign RGB      = rgb_q;
  assign video_on = video_on_q;
  assign h_sync   = h_sync_q;
  assign v_sync   = v_sync_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Scoreboard bench for vga_timing_core on a shrunken 14x8 raster with a
// divide-by-3 pixel clock, mixed sync polarities and a 2-frame blink period.
`timescale 1ns/1ps
module tb_vga_timing_core;

  localparam int CLK_DIV = 3;
  localparam int H_TOT   = 14;   // 8 + 2 + 3 + 1
  localparam int V_TOT   = 8;    // 4 + 1 + 2 + 1
  localparam int HS_POL  = 0;
  localparam int VS_POL  = 1;

  logic        CLK_NX = 1'b0;
  logic        reset;
  logic [11:0] color_in;
  logic        blink_en;
  logic        pixel_tick;
  logic [3:0]  pixel_x, pixel_y;
  logic        h_sync, v_sync, video_on, frame_start, blink;
  logic [11:0] RGB;

  vga_timing_core #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .COLOR_W(12), .CNT_W(4), .BLINK_FRAMES(2)
  ) dut (
    .CLK_NX(CLK_NX), .reset(reset), .color_in(color_in), .blink_en(blink_en),
    .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .h_sync(h_sync), .v_sync(v_sync), .video_on(video_on), .RGB(RGB),
    .frame_start(frame_start), .blink(blink)
  );

  always #5 CLK_NX = ~CLK_NX;

  typedef struct {
    logic [3:0]  x, y;
    logic [11:0] rgb;
    logic        vo, hs, vs, fs;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   k        = 0;   // rising edges since reset release
  logic run      = 1'b0;
  logic mon_en   = 1'b0;

  always @(posedge CLK_NX or negedge reset)
    if (!reset) k <= 0;
    else        k <= k + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (k=%0d)", nm, act, exp, k);
  endtask

  function automatic logic [11:0] col(input int n);
    if (n < H_TOT) return 12'hABC;
    return 12'(n * 309 + 241);
  endfunction

  function automatic exp_t init_entry();
    exp_t e;
    e.x = 4'd0; e.y = 4'd0; e.rgb = 12'h000;
    e.vo = 1'b0; e.hs = 1'b1; e.vs = 1'b0; e.fs = 1'b0;
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tick"},  32'(pixel_tick),  32'd0);
    chk({tag, "_x"},     32'(pixel_x),     32'd0);
    chk({tag, "_y"},     32'(pixel_y),     32'd0);
    chk({tag, "_rgb"},   32'(RGB),         32'd0);
    chk({tag, "_vo"},    32'(video_on),    32'd0);
    chk({tag, "_hs"},    32'(h_sync),      32'd1);
    chk({tag, "_vs"},    32'(v_sync),      32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
    chk({tag, "_blink"}, 32'(blink),       32'd0);
  endtask

  task automatic wait_k(input int t);
    int g = 0;
    do begin @(negedge CLK_NX); g++; end while (k != t && g < 5000);
    if (k != t) chk("wait_k_timeout", 32'(k), 32'(t));
  endtask

  // Stimulus: on each tick cycle present a colour and push the outputs
  // expected at the following tick; junk colour on every other cycle.
  initial begin : stim
    int n, x, y, nx, ny;
    logic [11:0] c;
    logic vis;
    exp_t e;
    color_in = 12'hFFF;
    forever begin
      @(negedge CLK_NX);
      if (run && reset) begin
        if (k % CLK_DIV == CLK_DIV - 1) begin
          n  = k / CLK_DIV;
          c  = col(n);
          color_in = c;
          x  = n % H_TOT;
          y  = (n / H_TOT) % V_TOT;
          nx = (n + 1) % H_TOT;
          ny = ((n + 1) / H_TOT) % V_TOT;
          vis   = (x < 8) && (y < 4);
          e.x   = 4'(nx);
          e.y   = 4'(ny);
          e.rgb = vis ? c : 12'h000;
          e.vo  = vis;
          e.hs  = (x >= 10 && x <= 12) ? 1'(HS_POL) : ~1'(HS_POL);
          e.vs  = (y >= 5 && y <= 6) ? 1'(VS_POL) : ~1'(VS_POL);
          e.fs  = (nx == H_TOT - 1) && (ny == V_TOT - 1);
          q.push_back(e);
        end else begin
          color_in = 12'($urandom);
        end
      end
    end
  end

  // Monitor: every cycle compares against the head entry; a tick consumes it.
  exp_t m_e;
  logic m_tick;
  always @(negedge CLK_NX) begin
    if (mon_en && reset) begin
      m_tick = (k % CLK_DIV) == CLK_DIV - 1;
      chk("pixel_tick", 32'(pixel_tick), 32'(m_tick));
      if (q.size() == 0) begin
        chk("sb_underflow", 32'(q.size()), 32'd1);
      end else begin
        m_e = q[0];
        chk("pixel_x",     32'(pixel_x),     32'(m_e.x));
        chk("pixel_y",     32'(pixel_y),     32'(m_e.y));
        chk("RGB",         32'(RGB),         32'(m_e.rgb));
        chk("video_on",    32'(video_on),    32'(m_e.vo));
        chk("h_sync",      32'(h_sync),      32'(m_e.hs));
        chk("v_sync",      32'(v_sync),      32'(m_e.vs));
        chk("frame_start", 32'(frame_start), 32'(m_tick && m_e.fs));
        if (pixel_tick) void'(q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    blink_en = 1'b0;
    reset    = 1'b1;
    #3 reset = 1'b0;
    repeat (2) @(negedge CLK_NX);
    check_reset_vals("rst0");
    repeat (2) @(negedge CLK_NX);
    check_reset_vals("rst1");

    @(negedge CLK_NX); #1;
    q.delete();
    q.push_back(init_entry());
    blink_en = 1'b1;
    run      = 1'b1;
    mon_en   = 1'b1;
    reset    = 1'b1;

    // Frame starts land on edges 336*f; blink period is 2 frames.
    wait_k(336);  chk("blink_f1", 32'(blink), 32'd0);
    wait_k(672);  chk("blink_f2", 32'(blink), 32'd1);
    wait_k(1008); chk("blink_f3", 32'(blink), 32'd1);
    wait_k(1050); #1 blink_en = 1'b0;
    wait_k(1051); chk("blink_drop", 32'(blink), 32'd0);
    #1 blink_en = 1'b1;
    wait_k(1344); chk("blink_f4", 32'(blink), 32'd0);
    wait_k(1680); chk("blink_f5", 32'(blink), 32'd1);

    // Tick 570 processes h_cnt=10, so h_sync is asserted (low) when reset hits.
    wait_k(1712); #1;
    mon_en = 1'b0;
    run    = 1'b0;
    @(posedge CLK_NX); #1;
    chk("pre_rst_hs", 32'(h_sync), 32'd0);
    #1 reset = 1'b0;
    #1 check_reset_vals("async");
    repeat (3) @(negedge CLK_NX);
    check_reset_vals("hold");

    @(negedge CLK_NX); #1;
    q.delete();
    q.push_back(init_entry());
    run    = 1'b1;
    mon_en = 1'b1;
    reset  = 1'b1;
    wait_k(336); chk("blink_restart", 32'(blink), 32'd0);
    wait_k(400);
    mon_en = 1'b0;
    run    = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
